// File: rtl/trace_dut_bridge.sv
// trace_dut_bridge
// Glue between a trace-replay ring port and a wide valid/ready DUT.
// Ring words are {opcode[1:0], payload[pay_w-1:0]}. The input side packs
// DATA/LAST payloads into one DUT input word, with chunk 0 in the LSBs. The
// output side splits each DUT result into ring words, LSB chunk first, and
// tags the final chunk with opcode 01. The two FSMs run independently.
//
// Handshake semantics:
//   A transfer happens on a rising edge where valid and ready (or yumi) are
//   both high. A valid that has been raised stays high, with its data held
//   stable, until that transfer. The yumi outputs (tr_yumi_o, dut_yumi_o)
//   mean "consumed this cycle". They depend only on the matching valid
//   input and on this block's own state.
module trace_dut_bridge #(
   parameter int ring_width_p = 10,
   parameter int in_width_p   = 512,
   parameter int out_width_p  = 256
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   // trace replay -> bridge
   input  logic                    tr_v_i,
   input  logic [ring_width_p-1:0] tr_data_i,
   output logic                    tr_yumi_o,
   // bridge -> DUT input
   output logic                    dut_v_o,
   output logic [in_width_p-1:0]   dut_data_o,
   input  logic                    dut_ready_i,
   // DUT result -> bridge
   input  logic                    dut_v_i,
   input  logic [out_width_p-1:0]  dut_data_i,
   output logic                    dut_yumi_o,
   // bridge -> trace replay
   output logic                    tr_v_o,
   output logic [ring_width_p-1:0] tr_data_o,
   input  logic                    tr_ready_i,
   // sticky protocol error
   output logic                    err_o,
   // debug: bit 1 = output FSM emitting, bit 0 = input FSM sending
   output logic [1:0]              dbg_state_o
);

   localparam int pay_w      = ring_width_p - 2;
   localparam int in_chunks  = (in_width_p + pay_w - 1) / pay_w;
   localparam int out_chunks = (out_width_p + pay_w - 1) / pay_w;
   localparam int in_buf_w   = in_chunks * pay_w;
   localparam int res_w      = out_chunks * pay_w;
   localparam int cnt_w      = $clog2(in_chunks + 1);
   localparam int idx_w      = (out_chunks > 1) ? $clog2(out_chunks) : 1;

   localparam logic [cnt_w-1:0] cnt_full = cnt_w'(in_chunks);
   localparam logic [idx_w-1:0] idx_last = idx_w'(out_chunks - 1);

   localparam logic [1:0] op_data  = 2'b00;
   localparam logic [1:0] op_last  = 2'b01;
   localparam logic [1:0] op_flush = 2'b10;

   typedef enum logic {
      in_fill = 1'b0,
      in_send = 1'b1
   } in_state_e;

   typedef enum logic {
      out_idle = 1'b0,
      out_emit = 1'b1
   } out_state_e;

   in_state_e            in_state;
   out_state_e           out_state;
   logic [cnt_w-1:0]     cnt;
   logic [in_buf_w-1:0]  in_buf;
   logic                 err_q;
   logic [idx_w-1:0]     idx;
   logic [res_w-1:0]     res;
   logic [pay_w-1:0]     emit_pay;
   logic [1:0]           emit_op;
   logic [1:0]           tr_op;
   logic [pay_w-1:0]     tr_pay;
   logic                 tr_take;
   logic                 res_take;

   assign tr_op  = tr_data_i[ring_width_p-1 -: 2];
   assign tr_pay = tr_data_i[pay_w-1:0];

   // Yumi outputs are gated by reset so every output reads 0 while reset is held.
   assign tr_take  = reset_n_i & tr_v_i & (in_state == in_fill);
   assign res_take = reset_n_i & dut_v_i & (out_state == out_idle);

   // Input FSM: collect payload chunks until LAST, then present the word to the DUT.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         in_state <= in_fill;
         cnt      <= '0;
         in_buf   <= '0;
         err_q    <= 1'b0;
      end else begin
         case (in_state)
            in_fill: begin
               if (tr_v_i) begin
                  case (tr_op)
                     op_data, op_last: begin
                        // A full buffer drops the payload. A LAST still closes the word.
                        if (cnt == cnt_full) begin
                           err_q <= 1'b1;
                        end else begin
                           for (int i = 0; i < in_chunks; i++) begin
                              if (cnt == cnt_w'(i)) in_buf[i*pay_w +: pay_w] <= tr_pay;
                           end
                           cnt <= cnt + cnt_w'(1);
                        end
                        if (tr_op == op_last) in_state <= in_send;
                     end
                     op_flush: begin
                        in_buf <= '0;
                        cnt    <= '0;
                     end
                     default: begin
                        // Reserved opcode: consumed but otherwise ignored.
                        err_q <= 1'b1;
                     end
                  endcase
               end
            end
            in_send: begin
               if (dut_ready_i) begin
                  in_buf   <= '0;
                  cnt      <= '0;
                  in_state <= in_fill;
               end
            end
            default: in_state <= in_fill;
         endcase
      end
   end

   // Output FSM: capture one DUT result, then emit its chunks LSB first.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         out_state <= out_idle;
         idx       <= '0;
         res       <= '0;
      end else begin
         case (out_state)
            out_idle: begin
               if (dut_v_i) begin
                  res       <= res_w'(dut_data_i);
                  idx       <= '0;
                  out_state <= out_emit;
               end
            end
            out_emit: begin
               if (tr_ready_i) begin
                  if (idx == idx_last) begin
                     idx       <= '0;
                     out_state <= out_idle;
                  end else begin
                     idx <= idx + idx_w'(1);
                  end
               end
            end
            default: out_state <= out_idle;
         endcase
      end
   end

   // Select the result chunk that is currently being emitted, and its opcode.
   always_comb begin
      emit_pay = '0;
      for (int i = 0; i < out_chunks; i++) begin
         if (idx == idx_w'(i)) emit_pay = res[i*pay_w +: pay_w];
      end
      emit_op = (idx == idx_last) ? op_last : op_data;
   end

   assign tr_yumi_o   = tr_take;
   assign dut_yumi_o  = res_take;
   assign dut_v_o     = (in_state == in_send);
   assign dut_data_o  = in_buf[in_width_p-1:0];
   assign tr_v_o      = (out_state == out_emit);
   assign tr_data_o   = (out_state == out_emit) ? {emit_op, emit_pay} : '0;
   assign err_o       = err_q;
   assign dbg_state_o = {out_state == out_emit, in_state == in_send};

endmodule

// File: tb/tb_trace_dut_bridge.sv
// tb_trace_dut_bridge
// Directed cases for the trace/DUT bridge, followed by a randomized phase.
// A transaction-level model predicts the packed DUT words, the ring words and
// the error flag. The handshake behaviour is checked on every cycle.
module tb_trace_dut_bridge;

  localparam int rw = 10;
  localparam int pw = 8;
  localparam int iw = 24;
  localparam int ow = 16;
  localparam int ic = 3;
  localparam int oc = 2;

  logic          clk;
  logic          reset_n_i;
  logic          tr_v_i;
  logic [rw-1:0] tr_data_i;
  logic          tr_yumi_o;
  logic          dut_v_o;
  logic [iw-1:0] dut_data_o;
  logic          dut_ready_i;
  logic          dut_v_i;
  logic [ow-1:0] dut_data_i;
  logic          dut_yumi_o;
  logic          tr_v_o;
  logic [rw-1:0] tr_data_o;
  logic          tr_ready_i;
  logic          err_o;
  logic [1:0]    dbg_state_o;

  trace_dut_bridge #(
    .ring_width_p(rw),
    .in_width_p  (iw),
    .out_width_p (ow)
  ) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n_i),
    .tr_v_i     (tr_v_i),
    .tr_data_i  (tr_data_i),
    .tr_yumi_o  (tr_yumi_o),
    .dut_v_o    (dut_v_o),
    .dut_data_o (dut_data_o),
    .dut_ready_i(dut_ready_i),
    .dut_v_i    (dut_v_i),
    .dut_data_i (dut_data_i),
    .dut_yumi_o (dut_yumi_o),
    .tr_v_o     (tr_v_o),
    .tr_data_o  (tr_data_o),
    .tr_ready_i (tr_ready_i),
    .err_o      (err_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [pw-1:0] pay_q[$];
  logic [iw-1:0] exp_in_q[$];
  logic [rw-1:0] exp_out_q[$];
  bit            m_err;
  bit            prev_dut_pend;
  bit            prev_tr_pend;
  logic [iw-1:0] prev_dut_data;
  logic [rw-1:0] prev_tr_data;

  function automatic void model_reset();
    pay_q.delete();
    exp_in_q.delete();
    exp_out_q.delete();
    m_err         = 1'b0;
    prev_dut_pend = 1'b0;
    prev_tr_pend  = 1'b0;
  endfunction

  function automatic void model_trace(input logic [rw-1:0] w);
    logic [iw-1:0] word;
    case (w[rw-1:rw-2])
      2'b00, 2'b01: begin
        if (pay_q.size() == ic) m_err = 1'b1;
        else pay_q.push_back(w[pw-1:0]);
        if (w[rw-1:rw-2] == 2'b01) begin
          word = '0;
          foreach (pay_q[i]) word = word | (iw'(pay_q[i]) << (pw * i));
          exp_in_q.push_back(word);
          pay_q.delete();
        end
      end
      2'b10:   pay_q.delete();
      default: m_err = 1'b1;
    endcase
  endfunction

  function automatic void model_result(input logic [ow-1:0] r);
    logic [1:0]    op;
    logic [pw-1:0] p;
    for (int i = 0; i < oc; i++) begin
      op = (i == oc - 1) ? 2'b01 : 2'b00;
      p  = pw'(r >> (pw * i));
      exp_out_q.push_back({op, p});
    end
  endfunction

  // ---------------- scoreboard / monitor ----------------
  // Inputs change 1 time unit after the rising edge. At the falling edge the
  // values show exactly what the next rising edge will act on.
  always @(negedge clk) begin
    if (reset_n_i) begin
      chk("err",      32'(err_o),      32'(m_err));
      chk("dut_v",    32'(dut_v_o),    32'(exp_in_q.size() != 0));
      chk("tr_v",     32'(tr_v_o),     32'(exp_out_q.size() != 0));
      chk("tr_yumi",  32'(tr_yumi_o),  32'(tr_v_i && exp_in_q.size() == 0));
      chk("dut_yumi", 32'(dut_yumi_o), 32'(dut_v_i && exp_out_q.size() == 0));
      if (prev_dut_pend) chk("dut_hold", 32'(dut_data_o), 32'(prev_dut_data));
      if (prev_tr_pend)  chk("tr_hold",  32'(tr_data_o),  32'(prev_tr_data));
      prev_dut_pend = dut_v_o && !dut_ready_i;
      prev_dut_data = dut_data_o;
      prev_tr_pend  = tr_v_o && !tr_ready_i;
      prev_tr_data  = tr_data_o;
      if (dut_v_o && dut_ready_i && exp_in_q.size() != 0)
        chk("dut_data", 32'(dut_data_o), 32'(exp_in_q.pop_front()));
      if (tr_v_o && tr_ready_i && exp_out_q.size() != 0)
        chk("tr_data", 32'(tr_data_o), 32'(exp_out_q.pop_front()));
      if (tr_yumi_o && tr_v_i)   model_trace(tr_data_i);
      if (dut_yumi_o && dut_v_i) model_result(dut_data_i);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_tr(input logic [1:0] op, input logic [pw-1:0] pay);
    bit got = 1'b0;
    tr_v_i    = 1'b1;
    tr_data_i = {op, pay};
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (tr_yumi_o) got = 1'b1;
      @(posedge clk);
      #1;
    end
    tr_v_i = 1'b0;
    chk("tr_accept", 32'(got), 32'd1);
  endtask

  task automatic send_res(input logic [ow-1:0] r);
    bit got = 1'b0;
    dut_v_i    = 1'b1;
    dut_data_i = r;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (dut_yumi_o) got = 1'b1;
      @(posedge clk);
      #1;
    end
    dut_v_i = 1'b0;
    chk("res_accept", 32'(got), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tr_yumi"},  32'(tr_yumi_o),   32'd0);
    chk({tag, "_dut_yumi"}, 32'(dut_yumi_o),  32'd0);
    chk({tag, "_dut_v"},    32'(dut_v_o),     32'd0);
    chk({tag, "_dut_data"}, 32'(dut_data_o),  32'd0);
    chk({tag, "_tr_v"},     32'(tr_v_o),      32'd0);
    chk({tag, "_tr_data"},  32'(tr_data_o),   32'd0);
    chk({tag, "_err"},      32'(err_o),       32'd0);
    chk({tag, "_dbg"},      32'(dbg_state_o), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  bit tr_done;
  bit res_done;

  initial begin
    model_reset();
    reset_n_i   = 1'b0;
    tr_v_i      = 1'b0;
    tr_data_i   = '0;
    dut_ready_i = 1'b0;
    dut_v_i     = 1'b0;
    dut_data_i  = '0;
    tr_ready_i  = 1'b0;
    tr_done     = 1'b0;
    res_done    = 1'b0;

    // Reset state, with both valid inputs raised.
    #2;
    tr_v_i  = 1'b1;
    dut_v_i = 1'b1;
    #1;
    chk_all_zero("rst");
    tr_v_i  = 1'b0;
    dut_v_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n_i = 1'b1;
    @(posedge clk);
    #1;

    // Pack three chunks; hold off DUT ready while a trace word waits.
    send_tr(2'b00, 8'h11);
    send_tr(2'b00, 8'h22);
    send_tr(2'b01, 8'h33);
    @(negedge clk);
    chk("t1_v",    32'(dut_v_o),    32'd1);
    chk("t1_data", 32'(dut_data_o), 32'h332211);
    chk("t1_err",  32'(err_o),      32'd0);
    @(posedge clk);
    #1;
    tr_v_i    = 1'b1;
    tr_data_i = {2'b00, 8'h77};
    repeat (5) begin
      @(negedge clk);
      chk("t1_yumi_hold", 32'(tr_yumi_o),  32'd0);
      chk("t1_data_hold", 32'(dut_data_o), 32'h332211);
      @(posedge clk);
      #1;
    end
    dut_ready_i = 1'b1;
    step(1);
    @(negedge clk);
    chk("t1_pending_taken", 32'(tr_yumi_o), 32'd1);
    @(posedge clk);
    #1;
    tr_v_i = 1'b0;
    send_tr(2'b10, 8'h00);

    // Serialise 0xBEEF; stall the ring for 5 cycles while a second result waits.
    tr_ready_i = 1'b0;
    send_res(16'hBEEF);
    dut_v_i    = 1'b1;
    dut_data_i = 16'h1234;
    repeat (5) begin
      @(negedge clk);
      chk("t2_tr_hold",   32'(tr_data_o),  32'h0EF);
      chk("t2_yumi_hold", 32'(dut_yumi_o), 32'd0);
      @(posedge clk);
      #1;
    end
    tr_ready_i = 1'b1;
    @(negedge clk);
    chk("t2_chunk0", 32'(tr_data_o), 32'h0EF);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t2_chunk1", 32'(tr_data_o), 32'h1BE);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t2_gap_v",    32'(tr_v_o),     32'd0);
    chk("t2_gap_yumi", 32'(dut_yumi_o), 32'd1);
    @(posedge clk);
    #1;
    dut_v_i = 1'b0;
    step(4);

    // A FLUSH discards the partial word.
    dut_ready_i = 1'b0;
    send_tr(2'b00, 8'hAA);
    send_tr(2'b10, 8'hFF);
    send_tr(2'b01, 8'h55);
    @(negedge clk);
    chk("t4_flush", 32'(dut_data_o), 32'h000055);
    @(posedge clk);
    #1;
    dut_ready_i = 1'b1;
    step(2);

    // Overflow: the fourth chunk is dropped and the error flag becomes sticky.
    dut_ready_i = 1'b0;
    send_tr(2'b00, 8'h01);
    send_tr(2'b00, 8'h02);
    send_tr(2'b00, 8'h03);
    send_tr(2'b00, 8'h44);
    @(negedge clk);
    chk("t3_err", 32'(err_o), 32'd1);
    @(posedge clk);
    #1;
    send_tr(2'b01, 8'h55);
    @(negedge clk);
    chk("t3_data",     32'(dut_data_o), 32'h030201);
    chk("t3_err_last", 32'(err_o),      32'd1);
    @(posedge clk);
    #1;
    dut_ready_i = 1'b1;
    step(2);

    // Reset in the middle of emitting, after chunk 0 has been sent.
    tr_ready_i = 1'b0;
    send_res(16'hCAFE);
    tr_ready_i = 1'b1;
    step(1);
    tr_ready_i = 1'b0;
    #2;
    reset_n_i = 1'b0;
    #1;
    chk_all_zero("t5_rst");
    model_reset();
    @(negedge clk) reset_n_i = 1'b1;
    @(posedge clk);
    #1;
    tr_ready_i = 1'b1;
    send_res(16'h1357);
    @(negedge clk);
    chk("t5_restart", 32'(tr_data_o), 32'h057);
    @(posedge clk);
    #1;
    step(3);

    // A reserved opcode raises the error flag.
    send_tr(2'b11, 8'h5A);
    @(negedge clk);
    chk("t6_reserved_err", 32'(err_o), 32'd1);
    @(posedge clk);
    #1;

    // Randomized traffic on all four ports.
    fork
      begin
        for (int k = 0; k < 120; k++) begin
          int r;
          logic [1:0] op;
          r  = $urandom_range(0, 15);
          op = (r < 9) ? 2'b00 : (r < 13) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
          send_tr(op, 8'($urandom));
          step($urandom_range(0, 2));
        end
        tr_done = 1'b1;
      end
      begin
        for (int k = 0; k < 40; k++) begin
          send_res(16'($urandom));
          step($urandom_range(0, 4));
        end
        res_done = 1'b1;
      end
      begin
        for (int c = 0; c < 20000 && !(tr_done && res_done); c++) begin
          dut_ready_i = ($urandom_range(0, 3) != 0);
          tr_ready_i  = ($urandom_range(0, 3) != 0);
          step(1);
        end
      end
    join
    dut_ready_i = 1'b1;
    tr_ready_i  = 1'b1;
    step(20);
    chk("drain_in",  32'(exp_in_q.size()),  32'd0);
    chk("drain_out", 32'(exp_out_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: abort if the run stops making progress.
  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
